// File: rtl/aludec_pipe.sv
// RV32I ALU decoder with an ID->EX register; optional RV32M launch FSM under ALUDEC_RV32M_EN.
// Latency: one cycle from ID inputs to registered outputs; M ops keep md_busy high for MD_LATENCY cycles.
// Backpressure: flush > (md_busy | stall) hold > capture; md_busy tells the hazard unit to stall ID/IF.
module aludec_pipe #(
    parameter int CTRL_W     = 4,
    parameter int MD_LATENCY = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic              opb5,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic              funct7b0,
    input  logic [1:0]        ALUOp,
    input  logic              stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ALUControl_E,
    output logic              illegal_E,
    output logic              md_start,
    output logic [2:0]        md_op,
    output logic              md_busy,
    output logic              md_done
);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    logic [3:0] base_ctrl;
    logic [3:0] dec_ctrl;
    logic       dec_illegal;
    logic       dec_is_m;
    logic       capture;

    always_comb begin
        base_ctrl   = ALU_ADD;
        dec_illegal = 1'b0;
        case (ALUOp)
            2'b00: base_ctrl = ALU_ADD;
            2'b01: base_ctrl = ALU_SUB;
            2'b11: dec_illegal = 1'b1;
            default: begin
                case (funct3)
                    3'b000:  base_ctrl = (opb5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  base_ctrl = ALU_SLL;
                    3'b010:  base_ctrl = ALU_SLT;
                    3'b011:  base_ctrl = ALU_SLTU;
                    3'b100:  base_ctrl = ALU_XOR;
                    3'b101:  base_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  base_ctrl = ALU_OR;
                    default: base_ctrl = ALU_AND;
                endcase
            end
        endcase
    end

`ifdef ALUDEC_RV32M_EN
    assign dec_is_m = (ALUOp == 2'b10) & opb5 & funct7b0 & ~funct7b5;
`else
    logic unused_funct7b0;
    assign unused_funct7b0 = funct7b0;
    assign dec_is_m        = 1'b0;
`endif

    // M ops drive the ALU as a plain add; the result comes from the M unit.
    assign dec_ctrl = dec_is_m ? ALU_ADD : base_ctrl;
    assign capture  = ~flush & ~md_busy & ~stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid     <= 1'b0;
            ALUControl_E <= '0;
            illegal_E    <= 1'b0;
        end else if (flush) begin
            ex_valid     <= 1'b0;
            ALUControl_E <= '0;
            illegal_E    <= 1'b0;
        end else if (capture) begin
            ex_valid     <= id_valid;
            ALUControl_E <= CTRL_W'(dec_ctrl);
            illegal_E    <= dec_illegal;
        end
    end

`ifdef ALUDEC_RV32M_EN
    localparam int CNT_W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

    md_state_t  state;
    md_state_t  state_nxt;
    logic [CNT_W-1:0] cnt;
    logic       m_launch;

    assign m_launch = capture & id_valid & dec_is_m;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= MD_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (m_launch) state_nxt = MD_BUSY;
            default: if (flush || cnt == '0) state_nxt = MD_IDLE;
        endcase
    end

    // The M unit runs independently of stall, so the counter ignores it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            md_start <= 1'b0;
            md_op    <= 3'b000;
        end else begin
            md_start <= m_launch;
            if (m_launch) begin
                cnt   <= CNT_W'(MD_LATENCY - 1);
                md_op <= funct3;
            end else if (flush) begin
                cnt <= '0;
            end else if (state == MD_BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_comb begin
        md_busy = (state == MD_BUSY);
        md_done = (state == MD_BUSY) && (cnt == '0);
    end
`else
    assign md_start = 1'b0;
    assign md_op    = 3'b000;
    assign md_busy  = 1'b0;
    assign md_done  = 1'b0;
`endif

endmodule
